stage_id_sb: RTL and testbench

STAGE_ID_SB -- requirements
Module: stage_id_sb

---
 rtl/stage_id_sb.sv | 146 ++++++++++++++
 tb/tb_stage_id_sb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_id_sb.sv
// Decode/issue slot with a per-thread register scoreboard: holds one instruction
// for EX, blocks RAW/WAW hazards on in-flight destinations and counts stall cycles.
module stage_id_sb #(
  parameter int N_THREADS = 4,
  parameter int N_REGS    = 32,
  parameter int XLEN      = 32,
  parameter int VA_W      = 32,
  localparam int TW       = (N_THREADS > 1) ? $clog2(N_THREADS) : 1,
  localparam int RW       = $clog2(N_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [TW-1:0]   if_thread,
  input  logic [VA_W-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            if_itlb_miss,
  input  logic            if_icache_miss,
  input  logic [RW-1:0]   if_rs1,
  input  logic [RW-1:0]   if_rs2,
  input  logic            if_use_rs1,
  input  logic            if_use_rs2,
  input  logic [RW-1:0]   if_dst,
  input  logic            if_wr_reg,
  output logic [TW-1:0]   rf_thread,
  output logic [RW-1:0]   rf_ra1,
  output logic [RW-1:0]   rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [TW-1:0]   ex_thread,
  output logic [VA_W-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic [RW-1:0]   ex_dst,
  output logic [XLEN-1:0] ex_r1,
  output logic [XLEN-1:0] ex_r2,
  output logic            ex_wr_reg,
  output logic            ex_itlb_miss,
  input  logic            wb_valid,
  input  logic [TW-1:0]   wb_thread,
  input  logic [RW-1:0]   wb_dst,
  input  logic            flush_valid,
  input  logic [TW-1:0]   flush_thread,
  output logic [31:0]     stall_cnt
);

  logic            v_q, v_d;
  logic [TW-1:0]   thread_q;
  logic [VA_W-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [RW-1:0]   dst_q;
  logic [XLEN-1:0] r1_q, r2_q;
  logic            wr_reg_q, itlb_q;
  logic [N_REGS-1:0] busy_q [N_THREADS];
  logic [N_REGS-1:0] busy_d [N_THREADS];
  logic [31:0]     stall_q, stall_d;

  logic slot_flush, handshake, slot_free;
  logic haz_rs1, haz_rs2, haz_dst, hazard;
  logic drop, accept, stall_inc, sb_set, sb_kill;

  assign rf_thread = if_thread;
  assign rf_ra1    = if_rs1;
  assign rf_ra2    = if_rs2;

  assign slot_flush = flush_valid && (flush_thread == thread_q);
  assign ex_valid   = v_q && !slot_flush;
  assign handshake  = ex_valid && ex_ready;
  assign slot_free  = !v_q || handshake;

  // Register 0 is hardwired, so it never participates in a hazard.
  assign haz_rs1 = if_use_rs1 && (if_rs1 != '0) && busy_q[if_thread][if_rs1];
  assign haz_rs2 = if_use_rs2 && (if_rs2 != '0) && busy_q[if_thread][if_rs2];
  assign haz_dst = if_wr_reg  && (if_dst != '0) && busy_q[if_thread][if_dst];
  assign hazard  = haz_rs1 || haz_rs2 || haz_dst;

  assign drop      = if_valid && (if_icache_miss || (flush_valid && (flush_thread == if_thread)));
  assign accept    = if_valid && !drop && slot_free && (if_itlb_miss || !hazard);
  assign if_ready  = !rst && (drop || accept);
  assign stall_inc = if_valid && !drop && slot_free && hazard && !if_itlb_miss;

  assign sb_set  = accept && if_wr_reg && !if_itlb_miss && (if_dst != '0);
  // A squashed slot never reaches EX, so nobody downstream will release its bit.
  assign sb_kill = v_q && slot_flush && wr_reg_q && (dst_q != '0);

  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_thread][wb_dst] = 1'b0;
    if (sb_kill)  busy_d[thread_q][dst_q]   = 1'b0;
    if (sb_set)   busy_d[if_thread][if_dst] = 1'b1;
  end

  always_comb begin
    v_d = v_q;
    if (accept)                       v_d = 1'b1;
    else if (handshake || slot_flush) v_d = 1'b0;
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_inc && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= 1'b0;
      stall_q  <= '0;
      thread_q <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
      dst_q    <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      wr_reg_q <= 1'b0;
      itlb_q   <= 1'b0;
      for (int unsigned t = 0; t < N_THREADS; t++) busy_q[t] <= '0;
    end else begin
      v_q     <= v_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      if (accept) begin
        thread_q <= if_thread;
        pc_q     <= if_pc;
        instr_q  <= if_instr;
        dst_q    <= if_dst;
        r1_q     <= rf_rd1;
        r2_q     <= rf_rd2;
        wr_reg_q <= if_wr_reg && !if_itlb_miss;
        itlb_q   <= if_itlb_miss;
      end
    end
  end

  assign ex_thread    = thread_q;
  assign ex_pc        = pc_q;
  assign ex_instr     = instr_q;
  assign ex_dst       = dst_q;
  assign ex_r1        = r1_q;
  assign ex_r2        = r2_q;
  assign ex_wr_reg    = wr_reg_q;
  assign ex_itlb_miss = itlb_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_stage_id_sb.sv
// Bench for stage_id_sb: directed vector table, hand sequences for stall/flush,
// then random traffic against a behavioural scoreboard model.
module tb_stage_id_sb;
  localparam int NT = 4;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [1:0]  if_thread;
  logic [31:0] if_pc, if_instr;
  logic        if_itlb_miss, if_icache_miss;
  logic [4:0]  if_rs1, if_rs2, if_dst;
  logic        if_use_rs1, if_use_rs2, if_wr_reg;
  logic [1:0]  rf_thread;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        ex_valid, ex_ready;
  logic [1:0]  ex_thread;
  logic [31:0] ex_pc, ex_instr;
  logic [4:0]  ex_dst;
  logic [31:0] ex_r1, ex_r2;
  logic        ex_wr_reg, ex_itlb_miss;
  logic        wb_valid;
  logic [1:0]  wb_thread;
  logic [4:0]  wb_dst;
  logic        flush_valid;
  logic [1:0]  flush_thread;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  stage_id_sb #(.N_THREADS(NT), .N_REGS(NR), .XLEN(32), .VA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_thread(if_thread),
    .if_pc(if_pc), .if_instr(if_instr), .if_itlb_miss(if_itlb_miss),
    .if_icache_miss(if_icache_miss), .if_rs1(if_rs1), .if_rs2(if_rs2),
    .if_use_rs1(if_use_rs1), .if_use_rs2(if_use_rs2), .if_dst(if_dst),
    .if_wr_reg(if_wr_reg), .rf_thread(rf_thread), .rf_ra1(rf_ra1),
    .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_thread(ex_thread),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_dst(ex_dst), .ex_r1(ex_r1),
    .ex_r2(ex_r2), .ex_wr_reg(ex_wr_reg), .ex_itlb_miss(ex_itlb_miss),
    .wb_valid(wb_valid), .wb_thread(wb_thread), .wb_dst(wb_dst),
    .flush_valid(flush_valid), .flush_thread(flush_thread),
    .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    if_valid = 0; if_thread = 0; if_pc = 0; if_instr = 0;
    if_itlb_miss = 0; if_icache_miss = 0;
    if_rs1 = 0; if_rs2 = 0; if_use_rs1 = 0; if_use_rs2 = 0;
    if_dst = 0; if_wr_reg = 0; rf_rd1 = 0; rf_rd2 = 0;
    ex_ready = 1; wb_valid = 0; wb_thread = 0; wb_dst = 0;
    flush_valid = 0; flush_thread = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; if_valid = 1; if_dst = 5; if_wr_reg = 1;
    @(posedge clk); #1;
    chk("rst_if_ready", if_ready, 0);
    @(posedge clk); #1;
    rst = 0; idle();
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_instr", ex_instr, 0);
    chk("rst_ex_wr", ex_wr_reg, 0);
  endtask

  task automatic issue(input int t, input int r1, input bit u1, input int d, input bit w);
    if_valid = 1; if_thread = t[1:0]; if_rs1 = r1[4:0]; if_use_rs1 = u1;
    if_rs2 = 0; if_use_rs2 = 0; if_dst = d[4:0]; if_wr_reg = w;
  endtask

  typedef struct {
    bit iv; int t; int rs1; bit u1; int rs2; bit u2; int dst; bit wr;
    bit itlb; bit icm; bit er;
    bit wbv; int wbt; int wbd; bit fv; int ft;
    bit e_rdy; bit e_exv; bit e_chkf; bit e_itlb; bit e_wr; int e_stall;
  } vec_t;

  vec_t tbl [20];

  // Random-phase reference state
  typedef struct { int t; bit [31:0] pc; bit [31:0] instr; int dst;
                   bit [31:0] r1; bit [31:0] r2; bit wr; bit itlb; } slot_t;
  typedef struct { int t; int d; } wb_t;
  bit           mv;
  slot_t        ms;
  bit [NR-1:0]  mbusy [NT];
  bit [31:0]    mstall;
  wb_t          pend [$];

  function automatic bit in_use(int t, int r);
    return (r != 0) && mbusy[t][r];
  endfunction

  initial begin
    rst = 1;
    idle();
    do_reset();

    // iv t rs1 u1 rs2 u2 dst wr itlb icm er | wbv wbt wbd | fv ft | rdy exv chkf itlb wr stall
    tbl[0]  = '{1,0,1,1,2,1,3,1,0,0,1, 0,0,0, 0,0, 1,0,0,0,0,0};
    tbl[1]  = '{1,0,3,1,0,0,4,1,0,0,1, 0,0,0, 0,0, 0,1,0,0,0,1};
    tbl[2]  = '{1,0,3,1,0,0,4,1,0,0,1, 0,0,0, 0,0, 0,0,0,0,0,2};
    tbl[3]  = '{1,0,3,1,0,0,4,1,0,0,1, 1,0,3, 0,0, 0,0,0,0,0,3};
    tbl[4]  = '{1,0,3,1,0,0,4,1,0,0,1, 0,0,0, 0,0, 1,0,0,0,0,3};
    tbl[5]  = '{1,1,4,1,0,0,6,1,0,0,1, 0,0,0, 0,0, 1,1,0,0,0,3};
    tbl[6]  = '{1,0,0,0,0,0,7,1,0,0,1, 1,0,7, 0,0, 1,1,1,0,1,3};
    tbl[7]  = '{1,0,7,1,0,0,0,0,0,0,1, 0,0,0, 0,0, 0,1,0,0,0,4};
    tbl[8]  = '{0,0,0,0,0,0,0,0,0,0,1, 1,0,7, 0,0, 0,0,0,0,0,4};
    tbl[9]  = '{1,0,0,1,0,0,0,1,0,0,1, 0,0,0, 0,0, 1,0,0,0,0,4};
    tbl[10] = '{1,0,0,0,0,1,0,1,0,0,1, 0,0,0, 0,0, 1,1,0,0,0,4};
    tbl[11] = '{1,0,0,0,0,0,9,1,0,1,0, 0,0,0, 0,0, 1,1,0,0,0,4};
    tbl[12] = '{1,0,4,1,0,0,8,1,1,0,1, 0,0,0, 0,0, 1,1,0,0,0,4};
    tbl[13] = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 0,0, 0,1,1,1,0,4};
    tbl[14] = '{1,0,0,0,0,0,8,1,0,0,1, 0,0,0, 0,0, 1,1,1,1,0,4};
    tbl[15] = '{1,0,0,0,0,0,4,1,0,0,1, 0,0,0, 0,0, 0,1,1,0,1,5};
    tbl[16] = '{0,0,0,0,0,0,0,0,0,0,1, 1,0,4, 0,0, 0,0,0,0,0,5};
    tbl[17] = '{1,0,0,0,0,0,4,1,0,0,1, 0,0,0, 0,0, 1,0,0,0,0,5};
    tbl[18] = '{1,0,0,0,0,0,9,1,0,0,1, 0,0,0, 1,0, 1,0,0,0,0,5};
    tbl[19] = '{1,0,4,1,0,0,0,0,0,0,1, 0,0,0, 0,0, 1,0,0,0,0,5};

    foreach (tbl[i]) begin
      if_valid = tbl[i].iv; if_thread = tbl[i].t[1:0];
      if_rs1 = tbl[i].rs1[4:0]; if_use_rs1 = tbl[i].u1;
      if_rs2 = tbl[i].rs2[4:0]; if_use_rs2 = tbl[i].u2;
      if_dst = tbl[i].dst[4:0]; if_wr_reg = tbl[i].wr;
      if_itlb_miss = tbl[i].itlb; if_icache_miss = tbl[i].icm;
      ex_ready = tbl[i].er; wb_valid = tbl[i].wbv;
      wb_thread = tbl[i].wbt[1:0]; wb_dst = tbl[i].wbd[4:0];
      flush_valid = tbl[i].fv; flush_thread = tbl[i].ft[1:0];
      if_pc = 32'h100 + i; if_instr = 32'hC000 + i;
      #1;
      chk($sformatf("vec%0d_if_ready", i), if_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_ex_valid", i), ex_valid, tbl[i].e_exv);
      if (tbl[i].e_chkf) begin
        chk($sformatf("vec%0d_ex_itlb", i), ex_itlb_miss, tbl[i].e_itlb);
        chk($sformatf("vec%0d_ex_wr", i), ex_wr_reg, tbl[i].e_wr);
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d_stall", i), stall_cnt, tbl[i].e_stall);
    end

    // EX backpressure: payload holds, then back-to-back transfer and reload
    do_reset();
    issue(1, 0, 0, 2, 1); if_pc = 32'h1000; if_instr = 32'hAAAA; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    #1; chk("bp_accept", if_ready, 1);
    @(posedge clk); #1;
    issue(2, 0, 0, 3, 1); if_pc = 32'h2000; if_instr = 32'hBBBB; rf_rd1 = 32'h33; ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ex_valid", ex_valid, 1);
      chk("bp_if_ready", if_ready, 0);
      chk("bp_ex_pc", ex_pc, 32'h1000);
      chk("bp_ex_thread", ex_thread, 1);
      chk("bp_ex_dst", ex_dst, 2);
      chk("bp_ex_r1", ex_r1, 32'h11);
      chk("bp_ex_r2", ex_r2, 32'h22);
      @(posedge clk); #1;
    end
    ex_ready = 1;
    #1;
    chk("bp_release_ready", if_ready, 1);
    chk("bp_release_valid", ex_valid, 1);
    @(posedge clk); #1;
    idle();
    #1;
    chk("bp_reload_valid", ex_valid, 1);
    chk("bp_reload_pc", ex_pc, 32'h2000);
    chk("bp_reload_instr", ex_instr, 32'hBBBB);
    chk("bp_reload_r1", ex_r1, 32'h33);

    // Flush of slot thread releases its busy bit; other-thread slot survives
    do_reset();
    issue(2, 0, 0, 5, 1); ex_ready = 0;
    #1; chk("fl_accept", if_ready, 1);
    @(posedge clk); #1;
    idle(); ex_ready = 0; flush_valid = 1; flush_thread = 2;
    #1; chk("fl_ex_valid", ex_valid, 0);
    @(posedge clk); #1;
    idle(); ex_ready = 0; issue(2, 5, 1, 0, 0);
    #1; chk("fl_bit_cleared", if_ready, 1);
    @(posedge clk); #1;
    idle(); issue(1, 0, 0, 6, 1);
    #1; chk("fl_t1_accept", if_ready, 1);
    @(posedge clk); #1;
    idle(); ex_ready = 0; flush_valid = 1; flush_thread = 2;
    #1; chk("fl_other_valid", ex_valid, 1);
    @(posedge clk); #1;
    idle();
    #1;
    chk("fl_other_kept", ex_valid, 1);
    chk("fl_other_thread", ex_thread, 1);
    chk("fl_other_dst", ex_dst, 6);
    @(posedge clk); #1;
    idle(); issue(1, 6, 1, 0, 0);
    #1; chk("fl_other_bit", if_ready, 0);
    @(posedge clk); #1;

    // Random traffic against the reference model
    do_reset();
    mv = 0; mstall = 0; pend.delete();
    for (int t = 0; t < NT; t++) mbusy[t] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit e_exv, e_drop, e_free, e_haz, e_acc, e_hs, e_kill;
      if_valid = ($urandom_range(0, 99) < 75);
      if_thread = 2'($urandom_range(0, NT - 1));
      if_rs1 = 5'($urandom_range(0, 7)); if_rs2 = 5'($urandom_range(0, 7));
      if_dst = 5'($urandom_range(0, 7));
      if_use_rs1 = $urandom_range(0, 1); if_use_rs2 = $urandom_range(0, 1);
      if_wr_reg = ($urandom_range(0, 99) < 60);
      if_itlb_miss = ($urandom_range(0, 99) < 8);
      if_icache_miss = ($urandom_range(0, 99) < 8);
      flush_valid = ($urandom_range(0, 99) < 8);
      flush_thread = 2'($urandom_range(0, NT - 1));
      ex_ready = ($urandom_range(0, 99) < 70);
      if_pc = $urandom; if_instr = $urandom; rf_rd1 = $urandom; rf_rd2 = $urandom;
      wb_thread = 2'($urandom_range(0, NT - 1)); wb_dst = 5'($urandom_range(0, 7));
      wb_valid = 0;
      if (pend.size() > 0 && $urandom_range(0, 99) < 35) begin
        wb_t w = pend.pop_front();
        wb_valid = 1; wb_thread = w.t[1:0]; wb_dst = w.d[4:0];
      end

      e_kill = mv && flush_valid && (int'(flush_thread) == ms.t);
      e_exv  = mv && !e_kill;
      e_hs   = e_exv && ex_ready;
      e_drop = if_valid && (if_icache_miss || (flush_valid && flush_thread == if_thread));
      e_free = !mv || e_hs;
      e_haz  = (if_use_rs1 && in_use(if_thread, if_rs1)) ||
               (if_use_rs2 && in_use(if_thread, if_rs2)) ||
               (if_wr_reg && in_use(if_thread, if_dst));
      e_acc  = if_valid && !e_drop && e_free && (if_itlb_miss || !e_haz);

      #1;
      chk("rnd_if_ready", if_ready, e_drop || e_acc);
      chk("rnd_ex_valid", ex_valid, e_exv);
      chk("rnd_stall", stall_cnt, mstall);
      chk("rnd_rf_ra1", rf_ra1, if_rs1);
      if (mv) begin
        chk("rnd_ex_thread", ex_thread, ms.t);
        chk("rnd_ex_pc", ex_pc, ms.pc);
        chk("rnd_ex_instr", ex_instr, ms.instr);
        chk("rnd_ex_dst", ex_dst, ms.dst);
        chk("rnd_ex_r1", ex_r1, ms.r1);
        chk("rnd_ex_r2", ex_r2, ms.r2);
        chk("rnd_ex_wr", ex_wr_reg, ms.wr);
        chk("rnd_ex_itlb", ex_itlb_miss, ms.itlb);
      end

      if (e_hs && ms.wr) pend.push_back('{ms.t, ms.dst});
      if (wb_valid) mbusy[wb_thread][wb_dst] = 1'b0;
      if (e_kill && ms.wr && ms.dst != 0) mbusy[ms.t][ms.dst] = 1'b0;
      if (e_acc && if_wr_reg && !if_itlb_miss && if_dst != 0) mbusy[if_thread][if_dst] = 1'b1;
      if (if_valid && !e_drop && e_free && e_haz && !if_itlb_miss && mstall != 32'hFFFF_FFFF)
        mstall++;
      if (e_acc) begin
        mv = 1;
        ms = '{int'(if_thread), if_pc, if_instr, int'(if_dst), rf_rd1, rf_rd2,
               if_wr_reg && !if_itlb_miss, if_itlb_miss};
      end else if (e_hs || e_kill) begin
        mv = 0;
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of traffic drops whatever the slot held
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
